gray_capture_ctrl: RTL and testbench

//  Sequences capture of the 8-bit grayscale pixel stream into a frame-buffer write port.

---
 rtl/gray_cap_pkg.sv | 25 ++
 rtl/gray_win_check.sv | 67 ++++++
 rtl/gray_capture_ctrl.sv | 174 +++++++++++++++++
 tb/tb_gray_capture_ctrl.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gray_cap_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gray_cap_pkg
//  Description : Shared definitions for the grayscale capture controller:
//                FSM state encoding, default widths, SOF coordinates.
//  Revision    : 1.0  initial release
// ============================================================================
package gray_cap_pkg;

  localparam int DEF_ADDR_W = 19;
  localparam int DEF_CNT_W  = 16;

  // Coordinates of the first pixel of a frame
  localparam int SOF_X = 0;
  localparam int SOF_Y = 0;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARM     = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } cap_state_t;

endpackage
`default_nettype wire

// File: rtl/gray_win_check.sv
`default_nettype none
// ============================================================================
//  Module      : gray_win_check
//  Description : Registered crop-window compare. Produces one-cycle-delayed
//                hit / sof flags together with the pixel and its FIFO-full
//                flag, so all four stay aligned for the controller.
//  Ports       : clk, rst         clock, sync active-high reset
//                dval, x, y       incoming pixel valid and coordinates
//                gray_in, full_in pixel value and write-FIFO full flag
//                x0, y0, w, h     latched window
//                hit, sof         registered compare results
//                gray, full       pixel value / full flag aligned with hit
//  Revision    : 1.0  initial release
// ============================================================================
module gray_win_check
  import gray_cap_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dval,
  input  logic [CNT_W-1:0] x,
  input  logic [CNT_W-1:0] y,
  input  logic [7:0]       gray_in,
  input  logic             full_in,
  input  logic [CNT_W-1:0] x0,
  input  logic [CNT_W-1:0] y0,
  input  logic [CNT_W-1:0] w,
  input  logic [CNT_W-1:0] h,
  output logic             hit,
  output logic             sof,
  output logic [7:0]       gray,
  output logic             full
);

  // One extra bit so x0+w / y0+h never wrap around
  logic [CNT_W:0] x_ext, y_ext, x_lo, y_lo, x_hi, y_hi;
  logic           in_x, in_y, sof_now;

  assign x_ext = {1'b0, x};
  assign y_ext = {1'b0, y};
  assign x_lo  = {1'b0, x0};
  assign y_lo  = {1'b0, y0};
  assign x_hi  = {1'b0, x0} + {1'b0, w};
  assign y_hi  = {1'b0, y0} + {1'b0, h};

  assign in_x    = (x_ext >= x_lo) && (x_ext < x_hi);
  assign in_y    = (y_ext >= y_lo) && (y_ext < y_hi);
  assign sof_now = dval && (x == CNT_W'(SOF_X)) && (y == CNT_W'(SOF_Y));

  always_ff @(posedge clk) begin
    if (rst) begin
      hit  <= 1'b0;
      sof  <= 1'b0;
      gray <= 8'd0;
      full <= 1'b0;
    end else begin
      hit  <= dval && in_x && in_y;
      sof  <= sof_now;
      gray <= gray_in;
      full <= full_in;
    end
  end

endmodule
`default_nettype wire

// File: rtl/gray_capture_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : gray_capture_ctrl
//  Description : Captures a cropped window of the 8-bit gray pixel stream
//                into a linear frame-buffer write port. Arms on iStart,
//                waits for SOF, writes window pixels at 0..W*H-1, then
//                reports done; single-shot or continuous.
//  Ports       : iCLK, iReset           clock, sync active-high reset
//                iStart/iStop           capture request / abort
//                iContinuous            re-arm after each frame
//                iWinX0/Y0/W/H          window, sampled at accepted iStart
//                iGray,iDval,iX/Y_Cont  pixel stream
//                iWrFull                write FIFO full
//                oWrEn/oWrData/oWrAddr  write port
//                oBusy,oDone,oShort,oOverflow,oFrameCnt  status
//  Revision    : 1.0  initial release
// ============================================================================
module gray_capture_ctrl
  import gray_cap_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              iCLK,
  input  logic              iReset,
  input  logic              iStart,
  input  logic              iStop,
  input  logic              iContinuous,
  input  logic [CNT_W-1:0]  iWinX0,
  input  logic [CNT_W-1:0]  iWinY0,
  input  logic [CNT_W-1:0]  iWinW,
  input  logic [CNT_W-1:0]  iWinH,
  input  logic [7:0]        iGray,
  input  logic              iDval,
  input  logic [CNT_W-1:0]  iX_Cont,
  input  logic [CNT_W-1:0]  iY_Cont,
  input  logic              iWrFull,
  output logic              oWrEn,
  output logic [7:0]        oWrData,
  output logic [ADDR_W-1:0] oWrAddr,
  output logic              oBusy,
  output logic              oDone,
  output logic              oShort,
  output logic              oOverflow,
  output logic [7:0]        oFrameCnt
);

  cap_state_t       state;
  logic [CNT_W-1:0] win_x0, win_y0, win_w, win_h;
  logic             cont;
  logic [ADDR_W:0]  area;
  logic [ADDR_W:0]  pix_cnt;

  logic             hit_q, sof_q, full_q;
  logic [7:0]       gray_q;

  logic [2*CNT_W-1:0] area_full;
  logic               take_hit, last_hit;

  gray_win_check #(.CNT_W(CNT_W)) u_win (
    .clk     (iCLK),
    .rst     (iReset),
    .dval    (iDval),
    .x       (iX_Cont),
    .y       (iY_Cont),
    .gray_in (iGray),
    .full_in (iWrFull),
    .x0      (win_x0),
    .y0      (win_y0),
    .w       (win_w),
    .h       (win_h),
    .hit     (hit_q),
    .sof     (sof_q),
    .gray    (gray_q),
    .full    (full_q)
  );

  assign area_full = {{CNT_W{1'b0}}, iWinW} * {{CNT_W{1'b0}}, iWinH};

  // In ARM only the SOF pixel itself may be taken; in CAPTURE a new SOF
  // terminates the frame and is never written.
  assign take_hit = hit_q && (((state == S_ARM) && sof_q) ||
                              ((state == S_CAPTURE) && !sof_q));
  assign last_hit = (pix_cnt + (ADDR_W+1)'(1)) == area;

  assign oBusy = (state != S_IDLE);

  always_ff @(posedge iCLK) begin
    if (iReset) begin
      state     <= S_IDLE;
      win_x0    <= '0;
      win_y0    <= '0;
      win_w     <= '0;
      win_h     <= '0;
      cont      <= 1'b0;
      area      <= '0;
      pix_cnt   <= '0;
      oWrEn     <= 1'b0;
      oWrData   <= 8'd0;
      oWrAddr   <= '0;
      oDone     <= 1'b0;
      oShort    <= 1'b0;
      oOverflow <= 1'b0;
      oFrameCnt <= 8'd0;
    end else begin
      oWrEn <= 1'b0;
      oDone <= 1'b0;
      if (iStop) begin
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: begin
            if (iStart) begin
              win_x0    <= iWinX0;
              win_y0    <= iWinY0;
              win_w     <= iWinW;
              win_h     <= iWinH;
              cont      <= iContinuous;
              area      <= area_full[ADDR_W:0];
              pix_cnt   <= '0;
              oOverflow <= 1'b0;
              if ((iWinW == '0) || (iWinH == '0)) begin
                // Empty window: complete immediately as a short frame
                state     <= S_DONE;
                oDone     <= 1'b1;
                oShort    <= 1'b1;
                oFrameCnt <= 8'd1;
              end else begin
                state     <= S_ARM;
                oShort    <= 1'b0;
                oFrameCnt <= 8'd0;
              end
            end
          end
          S_ARM: begin
            if (sof_q) state <= S_CAPTURE;
          end
          S_CAPTURE: begin
            if (sof_q) begin
              state     <= S_DONE;
              oDone     <= 1'b1;
              oShort    <= 1'b1;
              oFrameCnt <= oFrameCnt + 8'd1;
            end
          end
          S_DONE: begin
            pix_cnt <= '0;
            state   <= cont ? S_ARM : S_IDLE;
          end
          default: state <= S_IDLE;
        endcase

        if (take_hit) begin
          // A dropped pixel still consumes its address slot
          if (full_q) begin
            oOverflow <= 1'b1;
          end else begin
            oWrEn   <= 1'b1;
            oWrData <= gray_q;
            oWrAddr <= pix_cnt[ADDR_W-1:0];
          end
          pix_cnt <= pix_cnt + (ADDR_W+1)'(1);
          if (last_hit) begin
            state     <= S_DONE;
            oDone     <= 1'b1;
            oFrameCnt <= oFrameCnt + 8'd1;
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_gray_capture_ctrl.sv
`timescale 1ns/1ps
module tb_gray_capture_ctrl;

  localparam int ADDR_W = 19;
  localparam int CNT_W  = 16;

  logic              iCLK = 1'b0;
  logic              iReset, iStart, iStop, iContinuous;
  logic [CNT_W-1:0]  iWinX0, iWinY0, iWinW, iWinH;
  logic [7:0]        iGray;
  logic              iDval;
  logic [CNT_W-1:0]  iX_Cont, iY_Cont;
  logic              iWrFull;
  logic              oWrEn;
  logic [7:0]        oWrData;
  logic [ADDR_W-1:0] oWrAddr;
  logic              oBusy, oDone, oShort, oOverflow;
  logic [7:0]        oFrameCnt;

  always #5 iCLK = ~iCLK;

  gray_capture_ctrl #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .iCLK(iCLK), .iReset(iReset), .iStart(iStart), .iStop(iStop),
    .iContinuous(iContinuous), .iWinX0(iWinX0), .iWinY0(iWinY0),
    .iWinW(iWinW), .iWinH(iWinH), .iGray(iGray), .iDval(iDval),
    .iX_Cont(iX_Cont), .iY_Cont(iY_Cont), .iWrFull(iWrFull),
    .oWrEn(oWrEn), .oWrData(oWrData), .oWrAddr(oWrAddr), .oBusy(oBusy),
    .oDone(oDone), .oShort(oShort), .oOverflow(oOverflow),
    .oFrameCnt(oFrameCnt)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // ---------------- output monitor ----------------
  logic [31:0] wr_q[$];
  int          done_cnt;
  int          busy_low;
  bit          in_run;

  always @(negedge iCLK) begin
    if (oWrEn === 1'b1) wr_q.push_back(32'({oWrAddr, oWrData}));
    if (oDone === 1'b1) done_cnt++;
    if (in_run && (oBusy !== 1'b1)) busy_low++;
  end

  // ---------------- pixel stream + reference model ----------------
  int          px_x[$], px_y[$], px_gap[$];
  logic [7:0]  px_g[$];
  bit          px_f[$];

  logic [31:0] exp_q[$];
  int          exp_done;
  int          exp_short, exp_ovf;

  // full_mode: 0 none, 1 full on the 2nd window pixel of frame 0, 2 random
  task automatic build_frames(input int nfr, input int fw, input int fh,
                              input int full_mode,
                              input int x0, input int y0, input int w, input int h);
    int hits = 0;
    px_x.delete(); px_y.delete(); px_gap.delete(); px_g.delete(); px_f.delete();
    for (int f = 0; f < nfr; f++)
      for (int y = 0; y < fh; y++)
        for (int x = 0; x < fw; x++) begin
          bit hit = (x >= x0) && (x < x0 + w) && (y >= y0) && (y < y0 + h);
          bit fb  = 1'b0;
          if (full_mode == 1 && f == 0 && hit) begin
            if (hits == 1) fb = 1'b1;
            hits++;
          end else if (full_mode == 2) begin
            fb = ($urandom_range(0, 5) == 0);
          end
          px_x.push_back(x);
          px_y.push_back(y);
          px_g.push_back(8'($urandom_range(0, 255)));
          px_f.push_back(fb);
          px_gap.push_back((x == 0 && y == 0) ? 3 : (($urandom_range(0, 4) == 0) ? 1 : 0));
        end
  endtask

  // Frame-level behaviour: wait for SOF, take window pixels in raster
  // order until W*H taken; a new SOF before that ends the frame short and
  // is itself consumed.
  task automatic model(input int x0, input int y0, input int w, input int h,
                       input bit cont);
    int area = w * h;
    int cnt  = 0;
    int mode = 0;   // 0 waiting for SOF, 1 capturing, 2 finished
    exp_q.delete();
    exp_done = 0; exp_short = 0; exp_ovf = 0;
    foreach (px_x[i]) begin
      bit sof = (px_x[i] == 0) && (px_y[i] == 0);
      bit hit = (px_x[i] >= x0) && (px_x[i] < x0 + w) &&
                (px_y[i] >= y0) && (px_y[i] < y0 + h);
      if (mode == 2) continue;
      if (mode == 0) begin
        if (!sof) continue;
        mode = 1;
        cnt  = 0;
      end else if (sof) begin
        exp_done++;
        exp_short = 1;
        mode = cont ? 0 : 2;
        continue;
      end
      if (hit) begin
        if (px_f[i]) exp_ovf = 1;
        else exp_q.push_back(32'({ADDR_W'(cnt), px_g[i]}));
        cnt++;
        if (cnt == area) begin
          exp_done++;
          mode = cont ? 0 : 2;
        end
      end
    end
  endtask

  task automatic drive_range(input int from, input int to);
    for (int i = from; i < to; i++) begin
      repeat (px_gap[i]) begin
        @(negedge iCLK);
        iDval = 1'b0;
      end
      @(negedge iCLK);
      iDval   = 1'b1;
      iX_Cont = CNT_W'(px_x[i]);
      iY_Cont = CNT_W'(px_y[i]);
      iGray   = px_g[i];
      iWrFull = px_f[i];
    end
    @(negedge iCLK);
    iDval   = 1'b0;
    iWrFull = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge iCLK);
      iDval = 1'b0;
    end
  endtask

  task automatic do_start(input int x0, input int y0, input int w, input int h,
                          input bit cont);
    idle(2);
    @(negedge iCLK);
    wr_q.delete();
    done_cnt    = 0;
    busy_low    = 0;
    iStart      = 1'b1;
    iContinuous = cont;
    iWinX0 = CNT_W'(x0); iWinY0 = CNT_W'(y0);
    iWinW  = CNT_W'(w);  iWinH  = CNT_W'(h);
    @(negedge iCLK);
    iStart = 1'b0;
  endtask

  task automatic stop_pulse();
    @(negedge iCLK);
    iStop = 1'b1;
    @(negedge iCLK);
    iStop = 1'b0;
  endtask

  task automatic run_case(input string nm, input int x0, input int y0,
                          input int w, input int h, input bit cont,
                          input int nfr, input int fw, input int fh,
                          input int full_mode);
    int n;
    build_frames(nfr, fw, fh, full_mode, x0, y0, w, h);
    model(x0, y0, w, h, cont);
    do_start(x0, y0, w, h, cont);
    in_run = cont;
    drive_range(0, px_x.size());
    idle(6);
    in_run = 1'b0;
    stop_pulse();
    idle(2);
    check({nm, " nwr"}, wr_q.size(), exp_q.size());
    n = (wr_q.size() < exp_q.size()) ? wr_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check({nm, " wr"}, int'(wr_q[i]), int'(exp_q[i]));
    check({nm, " done"}, done_cnt, exp_done);
    check({nm, " framecnt"}, int'(oFrameCnt), exp_done % 256);
    check({nm, " short"}, int'(oShort), exp_short);
    check({nm, " ovf"}, int'(oOverflow), exp_ovf);
    check({nm, " busy_end"}, int'(oBusy), 0);
    if (cont) check({nm, " busy_low"}, busy_low, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    iReset = 1'b1; iStart = 1'b0; iStop = 1'b0; iContinuous = 1'b0;
    iWinX0 = '0; iWinY0 = '0; iWinW = '0; iWinH = '0;
    iGray = 8'd0; iDval = 1'b0; iX_Cont = '0; iY_Cont = '0; iWrFull = 1'b0;
    in_run = 1'b0; done_cnt = 0; busy_low = 0;
    repeat (3) @(negedge iCLK);
    check("rst wren", int'(oWrEn), 0);
    check("rst busy", int'(oBusy), 0);
    check("rst done", int'(oDone), 0);
    check("rst framecnt", int'(oFrameCnt), 0);
    iReset = 1'b0;

    run_case("t1", 0, 0, 4, 2, 1'b0, 1, 8, 4, 0);
    run_case("t2", 2, 1, 3, 2, 1'b0, 1, 8, 4, 0);
    run_case("t3", 1, 1, 3, 2, 1'b1, 3, 8, 4, 0);
    run_case("t4", 0, 0, 4, 2, 1'b0, 1, 8, 4, 1);
    if (wr_q.size() > 1) check("t4 addr2", int'(wr_q[1][26:8]), 2);
    else check("t4 nwr2", wr_q.size(), 7);
    run_case("t5", 0, 0, 4, 10, 1'b0, 2, 8, 4, 0);

    // iStop together with iStart mid-capture
    build_frames(2, 8, 4, 0, 0, 0, 8, 4);
    do_start(0, 0, 8, 4, 1'b0);
    drive_range(0, 12);
    iStop = 1'b1; iStart = 1'b1;
    @(negedge iCLK);
    iStop = 1'b0; iStart = 1'b0;
    check("t6 busy", int'(oBusy), 0);
    n = wr_q.size();
    check("t6 some_wr", int'(n > 0), 1);
    drive_range(12, px_x.size());
    idle(6);
    check("t6 no_wr_after", wr_q.size(), n);
    check("t6 done", done_cnt, 0);
    check("t6 busy_end", int'(oBusy), 0);

    // Empty window
    do_start(0, 0, 0, 3, 1'b0);
    check("t7 done", int'(oDone), 1);
    check("t7 short", int'(oShort), 1);
    check("t7 framecnt", int'(oFrameCnt), 1);
    @(negedge iCLK);
    check("t7 done_pulse", int'(oDone), 0);
    idle(2);
    check("t7 busy", int'(oBusy), 0);

    // Reset mid-frame
    build_frames(1, 8, 4, 2, 0, 0, 8, 4);
    do_start(0, 0, 8, 4, 1'b1);
    drive_range(0, 10);
    iReset = 1'b1;
    @(negedge iCLK);
    iReset = 1'b0;
    check("t8 wren", int'(oWrEn), 0);
    check("t8 data", int'(oWrData), 0);
    check("t8 addr", int'(oWrAddr), 0);
    check("t8 busy", int'(oBusy), 0);
    check("t8 done", int'(oDone), 0);
    check("t8 short", int'(oShort), 0);
    check("t8 ovf", int'(oOverflow), 0);
    check("t8 framecnt", int'(oFrameCnt), 0);
    n = done_cnt;
    drive_range(10, px_x.size());
    idle(4);
    check("t8 no_done", done_cnt, n);

    // Randomized windows, frame sizes, modes and FIFO-full patterns
    for (int r = 0; r < 24; r++) begin
      run_case("rnd",
               $urandom_range(0, 4), $urandom_range(0, 3),
               $urandom_range(1, 6), $urandom_range(1, 4),
               1'($urandom_range(0, 1)), $urandom_range(1, 3),
               $urandom_range(4, 9), $urandom_range(2, 5),
               ($urandom_range(0, 2) == 0) ? 2 : 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
